// File: rtl/if_fetch_stage.sv
// if_fetch_stage: instruction-fetch stage between the PC register and IF/ID.
// Issues one request/grant/response fetch at a time to instruction memory,
// loads the IF/ID register (pc, inst, valid) and returns pc+4 as next PC.
// fetch_busy_o freezes the PC register while a fetch is outstanding or a
// stalled response is parked in the skid buffer.
//
// Optional build macro IF_MISALIGN_TRAP_EN: adds id_misalign_o and turns a
// misaligned non-bubble PC into a valid NOP tagged for a later trap, rather
// than a silent bubble.
//
// state | meaning
// IDLE  | ready to issue a request for pc_i
// WAIT  | request granted, waiting for the response
// HOLD  | response parked in skid buffer while IF/ID is stalled

module if_fetch_stage #(
    parameter logic [31:0] BUBBLE_PC = 32'hFFFF_FF00,
    parameter logic [31:0] NOP_INST  = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_i,
    input  logic        stall_i,
    input  logic        flush_i,
    output logic [31:0] npc_o,
    output logic        fetch_busy_o,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_gnt_i,
    input  logic        imem_rvalid_i,
    input  logic [31:0] imem_rdata_i,
    output logic        id_valid_o,
    output logic [31:0] id_pc_o,
    output logic [31:0] id_inst_o
`ifdef IF_MISALIGN_TRAP_EN
    ,
    output logic        id_misalign_o
`endif
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HOLD = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_drop;
    logic [31:0] r_addr;
    logic [31:0] r_skid;

    logic        w_is_bubble;
    logic        w_misaligned;
    logic        w_req;
    logic        w_id_load;
    logic        w_id_valid_d;
    logic [31:0] w_id_pc_d;
    logic [31:0] w_id_inst_d;
    logic        w_discard;

    // Request qualification and memory-side outputs
    always_comb begin
        w_is_bubble  = (pc_i == BUBBLE_PC);
        w_misaligned = (pc_i[1:0] != 2'b00);
        w_req        = !rst && (r_state == S_IDLE) && !w_is_bubble
                       && !w_misaligned && !flush_i;
        w_discard    = r_drop || flush_i;
    end

    assign npc_o        = pc_i + 32'd4;
    assign imem_req_o   = w_req;
    assign imem_addr_o  = pc_i;
    assign fetch_busy_o = (r_state != S_IDLE) || (w_req && !imem_gnt_i);

    // Decide whether and with what IF/ID is loaded at the next edge
    always_comb begin
        w_id_load    = 1'b0;
        w_id_valid_d = 1'b0;
        w_id_pc_d    = pc_i;
        w_id_inst_d  = NOP_INST;
        case (r_state)
            S_IDLE: begin
                if (flush_i) begin
                    w_id_load = 1'b1;
                end else if (!stall_i && (w_is_bubble || w_misaligned)) begin
                    w_id_load = 1'b1;
`ifdef IF_MISALIGN_TRAP_EN
                    w_id_valid_d = !w_is_bubble;
`endif
                end
            end
            S_WAIT: begin
                if (imem_rvalid_i) begin
                    // A flushed fetch still completes on the bus; its data becomes a bubble
                    if (w_discard) begin
                        w_id_load = 1'b1;
                        w_id_pc_d = r_addr;
                    end else if (!stall_i) begin
                        w_id_load    = 1'b1;
                        w_id_valid_d = 1'b1;
                        w_id_pc_d    = r_addr;
                        w_id_inst_d  = imem_rdata_i;
                    end
                end
            end
            S_HOLD: begin
                if (flush_i) begin
                    w_id_load = 1'b1;
                end else if (!stall_i) begin
                    w_id_load    = 1'b1;
                    w_id_valid_d = 1'b1;
                    w_id_pc_d    = r_addr;
                    w_id_inst_d  = r_skid;
                end
            end
            default: begin
                w_id_load = 1'b0;
            end
        endcase
    end

    // Fetch FSM with registered IF/ID outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_drop     <= 1'b0;
            r_addr     <= 32'd0;
            r_skid     <= 32'd0;
            id_valid_o <= 1'b0;
            id_pc_o    <= 32'd0;
            id_inst_o  <= NOP_INST;
        end else begin
            if (w_id_load) begin
                id_valid_o <= w_id_valid_d;
                id_pc_o    <= w_id_pc_d;
                id_inst_o  <= w_id_inst_d;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_req && imem_gnt_i) begin
                        r_addr  <= pc_i;
                        r_drop  <= 1'b0;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (imem_rvalid_i) begin
                        r_drop <= 1'b0;
                        if (!w_discard && stall_i) begin
                            r_skid  <= imem_rdata_i;
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end else if (flush_i) begin
                        r_drop <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (flush_i || !stall_i) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef IF_MISALIGN_TRAP_EN
    logic w_trap;

    always_comb begin
        w_trap = (r_state == S_IDLE) && !flush_i && !stall_i
                 && w_misaligned && !w_is_bubble;
    end

    // Misalign tag follows every IF/ID load; set only for a trapped PC
    always_ff @(posedge clk) begin
        if (rst) begin
            id_misalign_o <= 1'b0;
        end else if (w_id_load) begin
            id_misalign_o <= w_trap;
        end
    end
`endif

endmodule
